// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package lc3_mem_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] IO_ADDR_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_HOLD = 3'd2,
    WR      = 3'd3,
    WR_HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/lc3_sram_array.sv
// Single-port word RAM: synchronous write, registered read, no reset.
module lc3_sram_array
  import lc3_mem_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 bus memory responder: fixed-wait-state OE/WE handshake onto on-chip RAM
// plus a one-word I/O window (switches read, hex display write).
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int                DEPTH_LOG2 = 10,
  parameter int                RD_LAT     = 2,
  parameter int                WR_CYC     = 3,
  parameter logic [DATA_W-1:0] IO_ADDR    = IO_ADDR_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        Rd_valid,
  output logic        Wr_done,
  output logic [15:0] Hex_out,
  output logic        Err,
  output logic [2:0]  state_dbg
);

  // Handshake: an access starts when exactly one strobe rises in IDLE and
  // lasts while it stays high; Rd_valid/Wr_done hold until the strobe drops.
  localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);
  localparam logic [1:0] WR_LAST = 2'(WR_CYC - 1);

  state_t      state, state_next;
  logic [1:0]  cnt;
  logic [1:0]  cyc_idx;
  logic [15:0] addr_q, wdata_q, data_q;
  logic [15:0] sw_meta, sw_sync;
  logic [15:0] cur_addr, cur_wdata, ram_rdata;
  logic        cur_io, from_ram, ram_we;
  logic        start, rd_load, commit, set_err;

  // The IDLE cycle is cycle 0 of an access and uses the live bus values.
  assign cur_addr  = (state == IDLE) ? ADDR : addr_q;
  assign cur_wdata = (state == IDLE) ? Data_from_CPU : wdata_q;
  assign cur_io    = (cur_addr == IO_ADDR);
  assign cyc_idx   = cnt + 2'd1;
  assign ram_we    = commit && !cur_io && !Reset;
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    rd_load    = 1'b0;
    commit     = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (Mem_OE && Mem_WE) begin
          set_err = 1'b1;
        end else if (Mem_OE) begin
          start = 1'b1;
          if (RD_LAT <= 1) begin
            rd_load    = 1'b1;
            state_next = RD_HOLD;
          end else begin
            state_next = RD;
          end
        end else if (Mem_WE) begin
          start = 1'b1;
          if (WR_CYC <= 1) begin
            commit     = 1'b1;
            state_next = WR_HOLD;
          end else begin
            state_next = WR;
          end
        end
      end
      RD: begin
        if (Mem_WE) begin
          set_err    = 1'b1;
          state_next = IDLE;
        end else if (!Mem_OE) begin
          state_next = IDLE;
        end else if (cyc_idx == RD_LAST) begin
          rd_load    = 1'b1;
          state_next = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (Mem_WE) set_err = 1'b1;
        if (Mem_WE || !Mem_OE) state_next = IDLE;
      end
      WR: begin
        if (Mem_OE) begin
          set_err    = 1'b1;
          state_next = IDLE;
        end else if (!Mem_WE) begin
          state_next = IDLE;
        end else if (cyc_idx == WR_LAST) begin
          commit     = 1'b1;
          state_next = WR_HOLD;
        end
      end
      WR_HOLD: begin
        if (Mem_OE) set_err = 1'b1;
        if (Mem_OE || !Mem_WE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      addr_q   <= 16'd0;
      wdata_q  <= 16'd0;
      data_q   <= 16'd0;
      from_ram <= 1'b0;
      sw_meta  <= 16'd0;
      sw_sync  <= 16'd0;
      Rd_valid <= 1'b0;
      Wr_done  <= 1'b0;
      Hex_out  <= 16'd0;
      Err      <= 1'b0;
    end else begin
      state    <= state_next;
      sw_meta  <= Switches;
      sw_sync  <= sw_meta;
      Rd_valid <= (state_next == RD_HOLD);
      Wr_done  <= (state_next == WR_HOLD);
      if (start) begin
        addr_q  <= ADDR;
        wdata_q <= Data_from_CPU;
        cnt     <= 2'd0;
      end else if (state == RD || state == WR) begin
        cnt <= cnt + 2'd1;
      end
      if (set_err) Err <= 1'b1;
      if (commit && cur_io) Hex_out <= cur_wdata;
      // A single-cycle read presents the RAM register directly for one cycle,
      // then freezes that word into data_q.
      if (from_ram) begin
        data_q   <= ram_rdata;
        from_ram <= 1'b0;
      end
      if (rd_load) begin
        if (cur_io) data_q <= sw_sync;
        else if (state == IDLE) from_ram <= 1'b1;
        else data_q <= ram_rdata;
      end
    end
  end

  assign Data_to_CPU = from_ram ? ram_rdata : data_q;

  lc3_sram_array #(.AW(DEPTH_LOG2)) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .addr  (cur_addr[DEPTH_LOG2-1:0]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: two instances (RD_LAT=2 and RD_LAT=1) driven in
// lockstep, read data checked by per-instance scoreboard monitors.
module tb_lc3_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        oe = 1'b0, we = 1'b0;
  logic [15:0] addr = 16'd0, wdata = 16'd0, sw = 16'd0;

  logic [15:0] d0, hex0, d1, hex1;
  logic        rv0, wd0, err0, rv1, wd1, err1;
  logic [2:0]  st0, st1;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] model_mem [0:1023];

  always #5 clk = ~clk;

  lc3_mem_responder #(.DEPTH_LOG2(10), .RD_LAT(2), .WR_CYC(3)) u_dut0 (
    .Clk(clk), .Reset(rst), .Mem_OE(oe), .Mem_WE(we), .ADDR(addr),
    .Data_from_CPU(wdata), .Switches(sw), .Data_to_CPU(d0), .Rd_valid(rv0),
    .Wr_done(wd0), .Hex_out(hex0), .Err(err0), .state_dbg(st0)
  );

  lc3_mem_responder #(.DEPTH_LOG2(10), .RD_LAT(1), .WR_CYC(3)) u_dut1 (
    .Clk(clk), .Reset(rst), .Mem_OE(oe), .Mem_WE(we), .ADDR(addr),
    .Data_from_CPU(wdata), .Switches(sw), .Data_to_CPU(d1), .Rd_valid(rv1),
    .Wr_done(wd1), .Hex_out(hex1), .Err(err1), .state_dbg(st1)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare on each rising edge of Rd_valid.
  initial begin
    logic prv0, prv1;
    prv0 = 1'b0;
    prv1 = 1'b0;
    forever begin
      @(negedge clk);
      if (rv0 && !prv0) begin
        if (exp_q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd0_unexpected act=%h exp=none", d0);
        end else begin
          chk("rd0_data", d0, exp_q0.pop_front());
        end
      end
      if (rv1 && !prv1) begin
        if (exp_q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd1_unexpected act=%h exp=none", d1);
        end else begin
          chk("rd1_data", d1, exp_q1.pop_front());
        end
      end
      prv0 = rv0;
      prv1 = rv1;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a);
    logic [15:0] e;
    logic [9:0]  idx;
    idx = a[9:0];
    e = (a == 16'hFFFF) ? sw : model_mem[idx];
    exp_q0.push_back(e);
    exp_q1.push_back(e);
    @(posedge clk); #1;
    addr = a;
    oe   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (i == 1) addr = ~a;
      @(negedge clk);
      chk($sformatf("rd_valid0_c%0d", i), {15'd0, rv0}, (i >= 2) ? 16'd1 : 16'd0);
      chk($sformatf("rd_valid1_c%0d", i), {15'd0, rv1}, (i >= 1) ? 16'd1 : 16'd0);
    end
    @(posedge clk); #1;
    oe   = 1'b0;
    addr = 16'd0;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int n);
    logic [9:0] idx;
    idx = a[9:0];
    @(posedge clk); #1;
    addr  = a;
    wdata = d;
    we    = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (i == 1) begin
        addr  = ~a;
        wdata = ~d;
      end
      @(negedge clk);
      chk($sformatf("wr_done0_c%0d", i), {15'd0, wd0}, 16'd0);
    end
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    chk("wr_done0_after", {15'd0, wd0}, (n >= 3) ? 16'd1 : 16'd0);
    chk("wr_done1_after", {15'd0, wd1}, (n >= 3) ? 16'd1 : 16'd0);
    @(posedge clk); #1;
    if (n >= 3 && a != 16'hFFFF) model_mem[idx] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sw = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", d0, 16'h0000);
    chk("rst_rd_valid", {15'd0, rv0}, 16'd0);
    chk("rst_wr_done", {15'd0, wd0}, 16'd0);
    chk("rst_hex", hex0, 16'h0000);
    chk("rst_err", {15'd0, err0}, 16'd0);

    do_write(16'h0005, 16'h1234, 3);
    do_read(16'h0005);

    do_read(16'hFFFF);
    do_write(16'h03FF, 16'h7777, 3);
    do_write(16'hFFFF, 16'h00A5, 3);
    chk("hex0_io_write", hex0, 16'h00A5);
    chk("hex1_io_write", hex1, 16'h00A5);
    do_read(16'h03FF);
    sw = 16'h1357;
    repeat (3) @(posedge clk);
    #1;
    do_read(16'hFFFF);

    do_write(16'h0010, 16'hCAFE, 3);
    do_write(16'h0010, 16'hDEAD, 2);
    do_read(16'h0010);

    do_write(16'h0405, 16'h4321, 3);
    do_read(16'h0005);
    do_read(16'h0405);

    do_write(16'h0020, 16'h1111, 3);
    @(posedge clk); #1;
    addr  = 16'h0020;
    wdata = 16'h2222;
    we    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_data", d0, 16'h0000);
    chk("midrst_wr_done", {15'd0, wd0}, 16'd0);
    chk("midrst_hex0", hex0, 16'h0000);
    chk("midrst_hex1", hex1, 16'h0000);
    chk("midrst_data1", d1, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    we  = 1'b0;
    @(posedge clk); #1;
    do_read(16'h0020);

    oe = 1'b1;
    we = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("both_err0", {15'd0, err0}, 16'd1);
    chk("both_err1", {15'd0, err1}, 16'd1);
    chk("both_state", {13'd0, st0}, 16'd0);
    @(posedge clk); #1;
    oe = 1'b0;
    we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", {15'd0, err0}, 16'd1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", {15'd0, err0}, 16'd0);

    exp_q1.push_back(model_mem[10'h005]);
    @(posedge clk); #1;
    addr = 16'h0005;
    oe   = 1'b1;
    @(posedge clk); #1;
    we = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_err", {15'd0, err0}, 16'd1);
    chk("abort_state", {13'd0, st0}, 16'd0);
    chk("abort_rd_valid", {15'd0, rv0}, 16'd0);
    @(posedge clk); #1;
    oe = 1'b0;
    we = 1'b0;
    do_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    chk("exp_q0_empty", 16'(exp_q0.size()), 16'd0);
    chk("exp_q1_empty", 16'(exp_q1.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
